// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and helpers for the fetch-PC sequencer.
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_TAKEN = 2'b01,
        BR_JUMP  = 2'b10,
        BR_RSVD  = 2'b11
    } branch_e;

    typedef enum logic [1:0] {
        PC_ST_BOOT  = 2'd0,
        PC_ST_RUN   = 2'd1,
        PC_ST_DRAIN = 2'd2
    } pc_state_e;

    // Reserved encoding is deliberately treated as "no branch".
    function automatic logic is_redirect(input logic ex_valid, input branch_e br);
        return ex_valid && ((br == BR_TAKEN) || (br == BR_JUMP));
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Pipeline-facing bundle of the fetch sequencer: EX redirect inputs, fetch handshake, flush pulses.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic              stall;
    logic              ex_valid;
    logic [1:0]        branch;
    logic [ADDR_W-1:0] target_addr;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              flush_if;
    logic              flush_id;
    logic              misalign;

    modport master (
        input  stall, ex_valid, branch, target_addr, fetch_ready,
        output fetch_valid, fetch_addr, flush_if, flush_id, misalign
    );

    modport slave (
        output stall, ex_valid, branch, target_addr, fetch_ready,
        input  fetch_valid, fetch_addr, flush_if, flush_id, misalign
    );

endinterface

// File: rtl/pc_sequencer_perf_counter.sv
// Saturating event counter used by the optional performance counters (PC_SEQ_PERF_EN).
module pc_perf_counter
    import pc_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC owner: sequential fetch, EX redirects with IF/ID flush, deferred redirect while a request waits.
// Optional redirect/stall counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    pc_sequencer_if.master      bus
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]    redirect_count,
    output logic [CNT_W-1:0]    stall_count
`endif
);

    pc_state_e         state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [ADDR_W-1:0] redirect_pc_d, redirect_pc_q;
    logic              fetch_valid_d, fetch_valid_q;
    logic              flush_d, flush_if_q, flush_id_q;
    logic              misalign_d, misalign_q;

    logic              redir;
    logic              tgt_misaligned;
    logic              fire;
    logic              pending;
    logic [ADDR_W-1:0] tgt;

    assign redir          = is_redirect(bus.ex_valid, branch_e'(bus.branch));
    assign tgt            = {bus.target_addr[ADDR_W-1:2], 2'b00};
    assign tgt_misaligned = |bus.target_addr[1:0];
    assign fire           = fetch_valid_q && bus.fetch_ready;
    assign pending        = fetch_valid_q && !bus.fetch_ready;

    // Request valid is a flop so a presented request can never be withdrawn by a late stall.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;

        unique case (state_q)
            PC_ST_BOOT: begin
                state_d       = PC_ST_RUN;
                fetch_valid_d = !bus.stall;
            end
            PC_ST_RUN: begin
                if (redir && !pending) begin
                    pc_d          = tgt;
                    flush_d       = 1'b1;
                    misalign_d    = tgt_misaligned;
                    fetch_valid_d = !bus.stall;
                end else if (redir) begin
                    redirect_pc_d = tgt;
                    misalign_d    = tgt_misaligned;
                    fetch_valid_d = 1'b1;
                    state_d       = PC_ST_DRAIN;
                end else if (pending) begin
                    fetch_valid_d = 1'b1;
                end else begin
                    if (fire) begin
                        pc_d = pc_q + ADDR_W'(PC_STEP);
                    end
                    fetch_valid_d = !bus.stall;
                end
            end
            PC_ST_DRAIN: begin
                if (redir) begin
                    redirect_pc_d = tgt;
                    misalign_d    = tgt_misaligned;
                end
                // Latest redirect wins, including one arriving on the accept cycle.
                if (bus.fetch_ready) begin
                    pc_d          = redir ? tgt : redirect_pc_q;
                    flush_d       = 1'b1;
                    fetch_valid_d = !bus.stall;
                    state_d       = PC_ST_RUN;
                end
            end
            default: begin
                state_d       = PC_ST_BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PC_ST_BOOT;
            pc_q          <= RESET_PC;
            redirect_pc_q <= '0;
            fetch_valid_q <= 1'b0;
            flush_if_q    <= 1'b0;
            flush_id_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_if_q    <= flush_d;
            flush_id_q    <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_addr  = pc_q;
    assign bus.flush_if    = flush_if_q;
    assign bus.flush_id    = flush_id_q;
    assign bus.misalign    = misalign_q;

`ifdef PC_SEQ_PERF_EN
    logic stall_in_run;
    assign stall_in_run = bus.stall && (state_q == PC_ST_RUN);

    pc_perf_counter u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_d),
        .count (redirect_count)
    );

    pc_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_in_run),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: per-cycle stimulus with expected outputs queued and checked after each edge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        fl;
        logic        mis;
    } exp_t;

    typedef struct {
        logic        st;
        logic        ev;
        logic [1:0]  br;
        logic [31:0] tg;
        logic        rdy;
        exp_t        e;
    } step_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    pc_sequencer_if bus ();

`ifdef PC_SEQ_PERF_EN
    logic [31:0] redirect_count;
    logic [31:0] stall_count;
`endif

    pc_sequencer #(
        .RESET_PC (RST_PC),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef PC_SEQ_PERF_EN
        ,
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic st, input logic ev, input logic [1:0] br,
                                 input logic [31:0] tg, input logic rdy, input logic v,
                                 input logic [31:0] a, input logic fl, input logic mis);
        step_t s;
        s.st = st; s.ev = ev; s.br = br; s.tg = tg; s.rdy = rdy;
        s.e.v = v; s.e.a = a; s.e.fl = fl; s.e.mis = mis;
        return s;
    endfunction

    // Drive one cycle of inputs, queue what must be seen after the edge, advance past the edge.
    task automatic apply(input step_t s);
        bus.stall       = s.st;
        bus.ex_valid    = s.ev;
        bus.branch      = s.br;
        bus.target_addr = s.tg;
        bus.fetch_ready = s.rdy;
        sb.push_back(s.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t  e;
        rst = 1'b1;
        bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.branch = 2'b00;
        bus.target_addr = '0; bus.fetch_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {1'b0, RST_PC, 3'b000}) begin
            n_err++;
            $display("FAIL reset_state got v=%b a=%h fi=%b fd=%b m=%b exp v=0 a=%h",
                     bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, RST_PC);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.fetch_valid, bus.fetch_addr} !== {1'b0, RST_PC}) begin
            n_err++;
            $display("FAIL boot_cycle got v=%b a=%h exp v=0 a=%h", bus.fetch_valid, bus.fetch_addr, RST_PC);
        end
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h100, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h104, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h108, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h10C, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {e.v, e.a, e.fl, e.fl, e.mis}) begin
                n_err++;
                $display("FAIL seq_fetch[%0d] got v=%b a=%h fi=%b fd=%b m=%b exp v=%b a=%h f=%b m=%b", i,
                         bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, e.v, e.a, e.fl, e.mis);
            end
        end
    endtask

    task automatic test_redirect();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 2'b01, 32'h200, 1, 1, 32'h200, 1, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   1, 1, 32'h204, 0, 0));
        st.push_back(mk(0, 1, 2'b11, 32'h300, 1, 1, 32'h208, 0, 0));
        st.push_back(mk(0, 0, 2'b10, 32'h340, 1, 1, 32'h20C, 0, 0));
        st.push_back(mk(0, 1, 2'b10, 32'h240, 1, 1, 32'h240, 1, 0));
        st.push_back(mk(0, 1, 2'b01, 32'h280, 1, 1, 32'h280, 1, 0));
        st.push_back(mk(0, 1, 2'b10, 32'h2C0, 1, 1, 32'h2C0, 1, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   1, 1, 32'h2C4, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {e.v, e.a, e.fl, e.fl, e.mis}) begin
                n_err++;
                $display("FAIL redirect[%0d] got v=%b a=%h fi=%b fd=%b m=%b exp v=%b a=%h f=%b m=%b", i,
                         bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, e.v, e.a, e.fl, e.mis);
            end
        end
    endtask

    task automatic test_drain();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(0, 0, 2'b00, 32'h0,   0, 1, 32'h2C4, 0, 0));
        st.push_back(mk(0, 1, 2'b01, 32'h400, 0, 1, 32'h2C4, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 32'h0,   0, 1, 32'h2C4, 0, 0));
        st.push_back(mk(0, 1, 2'b10, 32'h500, 0, 1, 32'h2C4, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   1, 1, 32'h500, 1, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   1, 1, 32'h504, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   0, 1, 32'h504, 0, 0));
        st.push_back(mk(0, 1, 2'b01, 32'h400, 0, 1, 32'h504, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   1, 1, 32'h400, 1, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,   1, 1, 32'h404, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 32'h0,   0, 1, 32'h404, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 32'h0,   0, 1, 32'h404, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 32'h0,   1, 0, 32'h408, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {e.v, e.a, e.fl, e.fl, e.mis}) begin
                n_err++;
                $display("FAIL drain[%0d] got v=%b a=%h fi=%b fd=%b m=%b exp v=%b a=%h f=%b m=%b", i,
                         bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, e.v, e.a, e.fl, e.mis);
            end
        end
    endtask

    task automatic test_stall();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 0, 2'b00, 32'h0,  1, 0, 32'h408, 0, 0));
        st.push_back(mk(1, 0, 2'b00, 32'h0,  1, 0, 32'h408, 0, 0));
        st.push_back(mk(1, 1, 2'b01, 32'h80, 1, 0, 32'h080, 1, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,  1, 1, 32'h080, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,  1, 1, 32'h084, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {e.v, e.a, e.fl, e.fl, e.mis}) begin
                n_err++;
                $display("FAIL stall[%0d] got v=%b a=%h fi=%b fd=%b m=%b exp v=%b a=%h f=%b m=%b", i,
                         bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, e.v, e.a, e.fl, e.mis);
            end
        end
    endtask

    task automatic test_misalign_wrap();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(0, 1, 2'b10, 32'h203,       1, 1, 32'h200,       1, 1));
        st.push_back(mk(0, 0, 2'b00, 32'h0,         1, 1, 32'h204,       0, 0));
        st.push_back(mk(0, 1, 2'b01, 32'hFFFF_FFF4, 1, 1, 32'hFFFF_FFF4, 1, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,         1, 1, 32'h0000_0000, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0,         1, 1, 32'h0000_0004, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {e.v, e.a, e.fl, e.fl, e.mis}) begin
                n_err++;
                $display("FAIL misalign_wrap[%0d] got v=%b a=%h fi=%b fd=%b m=%b exp v=%b a=%h f=%b m=%b", i,
                         bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, e.v, e.a, e.fl, e.mis);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        step_t st[$];
        exp_t  e;
        apply(mk(0, 1, 2'b01, 32'h703, 0, 1, 32'h4, 0, 1));
        e = sb.pop_front();
        n_vec++;
        if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.misalign} !== {e.v, e.a, e.fl, e.mis}) begin
            n_err++;
            $display("FAIL enter_drain got v=%b a=%h fi=%b m=%b exp v=%b a=%h f=%b m=%b",
                     bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.misalign, e.v, e.a, e.fl, e.mis);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {1'b0, RST_PC, 3'b000}) begin
            n_err++;
            $display("FAIL async_reset got v=%b a=%h fi=%b fd=%b m=%b exp v=0 a=%h",
                     bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, RST_PC);
        end
`ifdef PC_SEQ_PERF_EN
        n_vec++;
        if ({redirect_count, stall_count} !== 64'h0) begin
            n_err++;
            $display("FAIL perf_reset got rc=%h sc=%h exp 0 0", redirect_count, stall_count);
        end
`endif
        bus.ex_valid = 1'b0;
        bus.branch   = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h100, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h104, 0, 0));
        st.push_back(mk(0, 0, 2'b00, 32'h0, 1, 1, 32'h108, 0, 0));
        foreach (st[i]) begin
            apply(st[i]);
            e = sb.pop_front();
            n_vec++;
            if ({bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign} !== {e.v, e.a, e.fl, e.fl, e.mis}) begin
                n_err++;
                $display("FAIL post_reset[%0d] got v=%b a=%h fi=%b fd=%b m=%b exp v=%b a=%h f=%b m=%b", i,
                         bus.fetch_valid, bus.fetch_addr, bus.flush_if, bus.flush_id, bus.misalign, e.v, e.a, e.fl, e.mis);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_redirect();
        test_drain();
        test_stall();
        test_misalign_wrap();
        test_reset_mid_drain();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got %0d entries exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
